// File: rtl/lcd_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_bounce_gen
// Purpose  : Pixel source for the 800x480 LTM panel (1056x525 total timing).
//            Draws a one-pixel white border, a solid background and a square
//            box that moves once per frame and bounces off the panel edges.
//            Colour and the DEN/HD/VD strobes share one 2-stage pipeline, so
//            everything reaches the panel aligned.
// Ports    : CLK, RST              pixel clock, synchronous active-high reset
//            Columna[10:0]         horizontal counter, 0..1055
//            Fila[9:0]             vertical counter, 0..524
//            DEN_in, HD_in, VD_in  enable / active-low syncs from the timing gen
//            PAUSE                 holds the box in place while high
//            R, G, B [7:0]         pixel colour (0 outside the active area)
//            DEN_out, HD_out, VD_out  strobes delayed by 2 cycles
//            FRAME_TICK            one-cycle pulse per frame
// Revision : 1.0  initial release
// ============================================================================
module lcd_bounce_gen #(
    parameter int          H_START    = 216,
    parameter int          V_START    = 35,
    parameter int          H_ACTIVE   = 800,
    parameter int          V_ACTIVE   = 480,
    parameter int          BOX        = 32,
    parameter int          STEP       = 2,
    parameter logic [23:0] BG_RGB     = 24'h000040,
    parameter logic [23:0] BOX_RGB    = 24'hFF8000,
    parameter logic [23:0] BORDER_RGB = 24'hFFFFFF
) (
    input  wire logic        CLK,
    input  wire logic        RST,
    input  wire logic [10:0] Columna,
    input  wire logic [9:0]  Fila,
    input  wire logic        DEN_in,
    input  wire logic        HD_in,
    input  wire logic        VD_in,
    input  wire logic        PAUSE,
    output logic      [7:0]  R,
    output logic      [7:0]  G,
    output logic      [7:0]  B,
    output logic             DEN_out,
    output logic             HD_out,
    output logic             VD_out,
    output logic             FRAME_TICK
);

    // Offsets only need the low counter bits: the difference of the low bits
    // equals the low bits of the full difference.
    localparam logic [9:0]  c_H_START_LO = 10'(H_START);
    localparam logic [8:0]  c_V_START_LO = 9'(V_START);
    localparam logic [9:0]  c_TICK_ROW   = 10'(V_START + V_ACTIVE);
    localparam logic [9:0]  c_X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [8:0]  c_Y_LAST     = 9'(V_ACTIVE - 1);
    localparam logic [10:0] c_X_MAX      = 11'(H_ACTIVE - BOX);
    localparam logic [10:0] c_Y_MAX      = 11'(V_ACTIVE - BOX);
    localparam logic [9:0]  c_X_MAX_POS  = 10'(H_ACTIVE - BOX);
    localparam logic [8:0]  c_Y_MAX_POS  = 9'(V_ACTIVE - BOX);
    localparam logic [10:0] c_STEP       = 11'(STEP);
    localparam logic [9:0]  c_STEP_X     = 10'(STEP);
    localparam logic [8:0]  c_STEP_Y     = 9'(STEP);
    localparam logic [10:0] c_BOX_M1     = 11'(BOX - 1);

    // Stage 1
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic        r_den1;
    logic        r_hd1;
    logic        r_vd1;
    // Stage 2
    logic [23:0] r_rgb;
    logic        r_den2;
    logic        r_hd2;
    logic        r_vd2;
    logic        r_tick;
    // Box state
    logic [9:0]  r_box_x;
    logic [8:0]  r_box_y;
    logic        r_dx;
    logic        r_dy;

    logic        w_tick;
    logic [10:0] w_bx_sum;
    logic [10:0] w_by_sum;
    logic [9:0]  w_box_x_d;
    logic [8:0]  w_box_y_d;
    logic        w_dx_d;
    logic        w_dy_d;
    logic        w_border;
    logic        w_in_box;
    logic [10:0] w_bx_end;
    logic [10:0] w_by_end;
    logic [23:0] w_rgb_d;

    // First line after the active area, column 0: box moves during vblank.
    assign w_tick = (Columna == 11'd0) && (Fila == c_TICK_ROW);

    // Box motion; sums are 11 bits wide so the overshoot test cannot wrap.
    always_comb begin
        w_bx_sum  = {1'b0, r_box_x} + c_STEP;
        w_by_sum  = {2'b0, r_box_y} + c_STEP;
        w_box_x_d = r_box_x;
        w_box_y_d = r_box_y;
        w_dx_d    = r_dx;
        w_dy_d    = r_dy;
        if (w_tick && !PAUSE) begin
            if (r_dx) begin
                if (w_bx_sum >= c_X_MAX) begin
                    w_box_x_d = c_X_MAX_POS;
                    w_dx_d    = 1'b0;
                end else begin
                    w_box_x_d = w_bx_sum[9:0];
                end
            end else begin
                if ({1'b0, r_box_x} <= c_STEP) begin
                    w_box_x_d = 10'd0;
                    w_dx_d    = 1'b1;
                end else begin
                    w_box_x_d = r_box_x - c_STEP_X;
                end
            end
            if (r_dy) begin
                if (w_by_sum >= c_Y_MAX) begin
                    w_box_y_d = c_Y_MAX_POS;
                    w_dy_d    = 1'b0;
                end else begin
                    w_box_y_d = w_by_sum[8:0];
                end
            end else begin
                if ({2'b0, r_box_y} <= c_STEP) begin
                    w_box_y_d = 9'd0;
                    w_dy_d    = 1'b1;
                end else begin
                    w_box_y_d = r_box_y - c_STEP_Y;
                end
            end
        end
    end

    // Colour select for the stage-1 coordinate: border > box > background.
    always_comb begin
        w_bx_end = {1'b0, r_box_x} + c_BOX_M1;
        w_by_end = {2'b0, r_box_y} + c_BOX_M1;
        w_border = (r_x == 10'd0) || (r_x == c_X_LAST) ||
                   (r_y == 9'd0)  || (r_y == c_Y_LAST);
        w_in_box = (r_x >= r_box_x) && ({1'b0, r_x} <= w_bx_end) &&
                   (r_y >= r_box_y) && ({2'b0, r_y} <= w_by_end);
        w_rgb_d  = 24'h000000;
        if (r_den1) begin
            if (w_border) begin
                w_rgb_d = BORDER_RGB;
            end else if (w_in_box) begin
                w_rgb_d = BOX_RGB;
            end else begin
                w_rgb_d = BG_RGB;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x     <= 10'd0;
            r_y     <= 9'd0;
            r_den1  <= 1'b0;
            r_hd1   <= 1'b1;
            r_vd1   <= 1'b1;
            r_rgb   <= 24'h000000;
            r_den2  <= 1'b0;
            r_hd2   <= 1'b1;
            r_vd2   <= 1'b1;
            r_tick  <= 1'b0;
            r_box_x <= 10'd0;
            r_box_y <= 9'd0;
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
        end else begin
            r_x     <= Columna[9:0] - c_H_START_LO;
            r_y     <= Fila[8:0] - c_V_START_LO;
            r_den1  <= DEN_in;
            r_hd1   <= HD_in;
            r_vd1   <= VD_in;
            r_rgb   <= w_rgb_d;
            r_den2  <= r_den1;
            r_hd2   <= r_hd1;
            r_vd2   <= r_vd1;
            r_tick  <= w_tick;
            r_box_x <= w_box_x_d;
            r_box_y <= w_box_y_d;
            r_dx    <= w_dx_d;
            r_dy    <= w_dy_d;
        end
    end

    assign R          = r_rgb[23:16];
    assign G          = r_rgb[15:8];
    assign B          = r_rgb[7:0];
    assign DEN_out    = r_den2;
    assign HD_out     = r_hd2;
    assign VD_out     = r_vd2;
    assign FRAME_TICK = r_tick;

endmodule
`default_nettype wire
